// File: rtl/hdmi_video_capture.sv
// -----------------------------------------------------------------------------
// hdmi_video_capture
//
// Sink-side raster capture for a DE/HSYNC/VSYNC/RGB video stream. The block
// locks onto the incoming raster once a full frame of exactly
// H_ACTIVE x V_ACTIVE active pixels has been seen. While locked it converts
// each active pixel to 8-bit luma and writes it, in raster order, to a
// frame-buffer write port.
//
// Parameters
//   H_ACTIVE   active pixels per line the raster must match
//   V_ACTIVE   active lines per frame the raster must match
//   ADDR_W     frame-buffer address width (H_ACTIVE*V_ACTIVE must fit)
//
// Ports
//   CLK_PX      in   pixel clock, the only clock
//   RST         in   synchronous reset, active-high
//   DE          in   data enable, high during active pixels
//   HSYNC       in   horizontal sync, active-low (sampled, not used for timing)
//   VSYNC       in   vertical sync, active-low; falling edge marks a new frame
//   RED/GREEN/BLUE in 8-bit pixel components
//   WR_EN       out  frame-buffer write strobe
//   WR_ADDR     out  frame-buffer write address
//   WR_DATA     out  luma = (R + 2G + B) / 4
//   LOCKED      out  raster matches the expected geometry, writes enabled
//   FRAME_DONE  out  1-cycle pulse: a locked frame was captured without error
//   FMT_ERR     out  1-cycle pulse: geometry violation while locked
//   H_MEAS      out  DE run length of the most recent line
//   V_MEAS      out  DE line count of the most recent frame
//   CHECKSUM    out  (HDMI_CAP_CHECKSUM_EN only) mod-2^24 sum of the luma
//                    written in the last completed frame
//
// Build option
//   HDMI_CAP_CHECKSUM_EN  when defined, adds the CHECKSUM port and its
//                         accumulator; when undefined, neither exists.
//
// Pipeline: pins -> S1 input registers -> registered WR_* outputs, so a pixel
// at the pins appears on the write port two clocks later.
// -----------------------------------------------------------------------------
module hdmi_video_capture #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int ADDR_W   = 19
) (
  input  logic              CLK_PX,
  input  logic              RST,
  input  logic              DE,
  input  logic              HSYNC,
  input  logic              VSYNC,
  input  logic [7:0]        RED,
  input  logic [7:0]        GREEN,
  input  logic [7:0]        BLUE,
  output logic              WR_EN,
  output logic [ADDR_W-1:0] WR_ADDR,
  output logic [7:0]        WR_DATA,
  output logic              LOCKED,
  output logic              FRAME_DONE,
  output logic              FMT_ERR,
  output logic [9:0]        H_MEAS,
  output logic [9:0]        V_MEAS
`ifdef HDMI_CAP_CHECKSUM_EN
  ,
  output logic [23:0]       CHECKSUM
`endif
);

  // The write-address counter carries one extra bit so that the value
  // H_ACTIVE*V_ACTIVE (one past the last pixel) is representable even when
  // the frame exactly fills the 2^ADDR_W address space.
  localparam int                FRAME_PIX  = H_ACTIVE * V_ACTIVE;
  localparam int                CNT_W      = ADDR_W + 1;
  localparam logic [CNT_W-1:0]  ADDR_LIMIT = CNT_W'(FRAME_PIX);
  localparam logic [9:0]        H_TGT      = 10'(H_ACTIVE);
  localparam logic [9:0]        V_TGT      = 10'(V_ACTIVE);
  localparam logic [9:0]        CNT_MAX    = 10'h3FF;

  typedef enum logic [1:0] {
    SEEK,
    MEASURE,
    LOCK
  } state_t;

  // Luma at 10 bits: max 255 + 510 + 255 = 1020 fits, so no overflow.
  // Dropping the two LSBs divides by 4; grey input returns the grey value.
  function automatic logic [7:0] luma_of(input logic [7:0] r,
                                         input logic [7:0] g,
                                         input logic [7:0] b);
    logic [9:0] sum;
    sum = {2'b00, r} + {1'b0, g, 1'b0} + {2'b00, b};
    return 8'(sum >> 2);
  endfunction

  // ---------------------------------------------------------------------------
  // Input stage S1 and the delayed copy used for edge detection
  // ---------------------------------------------------------------------------
  logic       de_s1, vs_s1, hs_s1;
  logic [7:0] red_s1, green_s1, blue_s1;
  logic       de_d, vs_d;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of its neighbours, independent of block order.
  always_ff @(posedge CLK_PX) begin
    if (RST) begin
      // Sync registers clear to 0 so that VSYNC idling high after reset shows
      // a rising edge, never a spurious frame marker.
      de_s1    <= 1'b0;
      vs_s1    <= 1'b0;
      hs_s1    <= 1'b0;
      red_s1   <= '0;
      green_s1 <= '0;
      blue_s1  <= '0;
      de_d     <= 1'b0;
      vs_d     <= 1'b0;
    end else begin
      de_s1    <= DE;
      vs_s1    <= VSYNC;
      hs_s1    <= HSYNC;
      red_s1   <= RED;
      green_s1 <= GREEN;
      blue_s1  <= BLUE;
      de_d     <= de_s1;
      vs_d     <= vs_s1;
    end
  end

  // HSYNC carries nothing the capture needs: lines are delimited by DE and
  // frames by VSYNC alone. It is sampled with the other inputs and left unused.
  logic unused_hsync;
  assign unused_hsync = hs_s1;

  logic frame_marker;
  logic line_end;
  assign frame_marker = vs_d & ~vs_s1;
  assign line_end     = de_d & ~de_s1;

  logic [7:0] luma;
  assign luma = luma_of(red_s1, green_s1, blue_s1);

  // ---------------------------------------------------------------------------
  // Raster measurement counters
  // ---------------------------------------------------------------------------
  logic [9:0] pix_cnt;
  logic [9:0] line_cnt;
  logic [9:0] line_cnt_eff;

  // Line count including a line that ends in this very cycle, so a line end
  // coinciding with the frame marker is still credited to the closing frame.
  assign line_cnt_eff = (line_end && line_cnt != CNT_MAX) ? line_cnt + 10'd1
                                                          : line_cnt;

  always_ff @(posedge CLK_PX) begin
    if (RST) begin
      pix_cnt  <= '0;
      line_cnt <= '0;
      H_MEAS   <= '0;
      V_MEAS   <= '0;
    end else begin
      // line_end implies DE is low now, so clear and increment never collide.
      if (line_end) begin
        pix_cnt <= '0;
        H_MEAS  <= pix_cnt;
      end else if (de_s1 && pix_cnt != CNT_MAX) begin
        pix_cnt <= pix_cnt + 10'd1;
      end

      if (frame_marker) begin
        V_MEAS   <= line_cnt_eff;
        line_cnt <= '0;
      end else begin
        line_cnt <= line_cnt_eff;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Per-cycle decisions. The frame marker is resolved before the pixel that
  // shares its cycle, so such a pixel lands at address 0 of the new frame.
  // ---------------------------------------------------------------------------
  state_t           state;
  logic             lines_ok;
  logic [CNT_W-1:0] addr_cnt;

  logic             line_bad;
  logic             frame_ok;
  logic             measure_pass;
  logic             capture;
  logic [CNT_W-1:0] base_addr;
  logic             pix_write;
  logic             overflow;
  logic             lock_err;
  logic             done;

  // NOTE: every signal gets a value on every pass through always_comb;
  // a path that leaves one unassigned would infer a latch.
  always_comb begin
    line_bad     = line_end && (pix_cnt != H_TGT);
    frame_ok     = (line_cnt_eff == V_TGT);
    measure_pass = (state == MEASURE) && frame_marker && lines_ok
                   && !line_bad && frame_ok;
    // Writes are enabled in LOCK unless this marker closes a short/long frame,
    // and also on the very marker that promotes MEASURE to LOCK.
    capture      = measure_pass
                   || ((state == LOCK) && !(frame_marker && !frame_ok));
    base_addr    = frame_marker ? '0 : addr_cnt;
    pix_write    = capture && de_s1 && (base_addr != ADDR_LIMIT);
    overflow     = capture && de_s1 && (base_addr == ADDR_LIMIT);
    lock_err     = (state == LOCK)
                   && (line_bad || (frame_marker && !frame_ok) || overflow);
    done         = (state == LOCK) && frame_marker && frame_ok && !line_bad;
  end

  // ---------------------------------------------------------------------------
  // Lock state machine with registered status outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK_PX) begin
    if (RST) begin
      state      <= SEEK;
      lines_ok   <= 1'b0;
      LOCKED     <= 1'b0;
      FRAME_DONE <= 1'b0;
      FMT_ERR    <= 1'b0;
    end else begin
      FRAME_DONE <= done;
      FMT_ERR    <= lock_err;

      case (state)
        SEEK: begin
          if (frame_marker) begin
            state    <= MEASURE;
            lines_ok <= 1'b1;
          end
        end

        MEASURE: begin
          if (frame_marker) begin
            // Either way a fresh measurement frame starts here.
            lines_ok <= 1'b1;
            if (measure_pass) begin
              state  <= LOCK;
              LOCKED <= 1'b1;
            end
          end else if (line_bad) begin
            lines_ok <= 1'b0;
          end
        end

        LOCK: begin
          if (lock_err) begin
            state  <= SEEK;
            LOCKED <= 1'b0;
          end
        end

        default: begin
          state  <= SEEK;
          LOCKED <= 1'b0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Frame-buffer write port
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK_PX) begin
    if (RST) begin
      WR_EN    <= 1'b0;
      WR_ADDR  <= '0;
      WR_DATA  <= '0;
      addr_cnt <= '0;
    end else begin
      WR_EN <= pix_write;
      if (pix_write) begin
        WR_ADDR  <= base_addr[ADDR_W-1:0];
        WR_DATA  <= luma;
        addr_cnt <= base_addr + CNT_W'(1);
      end else if (frame_marker) begin
        WR_ADDR  <= '0;
        addr_cnt <= '0;
      end
    end
  end

`ifdef HDMI_CAP_CHECKSUM_EN
  // ---------------------------------------------------------------------------
  // Frame checksum: accumulates the luma written since the last marker and is
  // published only when the frame completes cleanly; errored frames leave the
  // previously published value in place.
  // ---------------------------------------------------------------------------
  logic [23:0] csum_acc;

  always_ff @(posedge CLK_PX) begin
    if (RST) begin
      csum_acc <= '0;
      CHECKSUM <= '0;
    end else begin
      if (done) begin
        CHECKSUM <= csum_acc;
      end
      if (frame_marker) begin
        // A pixel sharing the marker cycle is the first of the new frame.
        csum_acc <= pix_write ? 24'(luma) : '0;
      end else if (pix_write) begin
        csum_acc <= csum_acc + 24'(luma);
      end
    end
  end
`endif

endmodule
